// File: rtl/tdes_cbc.sv
// tdes_cbc: CBC chaining controller in front of an external TDES core.
//
// Accepts 64-bit blocks from upstream, combines them with the running chain
// value, hands key/mode/data to the TDES core through a valid/ready start
// handshake, collects the core result and presents it downstream under
// backpressure.
//
// Ports:
//   clk_i, reset_i            clock (rising edge), async active-low reset
//   cbc_i                     (TDES_CBC_ECB_EN only) 1 = CBC, 0 = ECB
//   mode_i                    0 = encrypt, 1 = decrypt (sampled on accept)
//   start_i, iv_i             start a new chain from iv_i (sampled on accept)
//   key1_i..key3_i            three independent TDES keys (sampled on accept)
//   data_i, valid_i, ready_o  upstream block handshake
//   data_o, valid_o, ready_i  downstream result handshake
//   core_*_o                  mode/keys/data/start towards the TDES core
//   core_ready_i              TDES core can take a start
//   core_data_i, core_valid_i TDES core result and its one-cycle strobe
//
// Configuration macro: TDES_CBC_ECB_EN adds the cbc_i port so that ECB
// operation can be selected per block. Without it the block is always CBC.

module tdes_cbc (
  input  logic        clk_i,
  input  logic        reset_i,
`ifdef TDES_CBC_ECB_EN
  input  logic        cbc_i,
`endif
  input  logic        mode_i,
  input  logic        start_i,
  input  logic [63:0] key1_i,
  input  logic [63:0] key2_i,
  input  logic [63:0] key3_i,
  input  logic [63:0] iv_i,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        core_mode_o,
  output logic [63:0] core_key1_o,
  output logic [63:0] core_key2_o,
  output logic [63:0] core_key3_o,
  output logic [63:0] core_data_o,
  output logic        core_valid_o,
  input  logic        core_ready_i,
  input  logic [63:0] core_data_i,
  input  logic        core_valid_i
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, OUT} state_t;

  state_t      state_q, state_d;
  logic        mode_q;
  logic [63:0] key1_q, key2_q, key3_q;
  logic [63:0] in_q;
  logic [63:0] chain_q;
  logic [63:0] chain_new;
  logic [63:0] core_data_q;
  logic [63:0] data_q;
  logic        accept;
  logic        in_cbc;
  logic        cbc_q;

  assign accept = valid_i && (state_q == IDLE);

`ifdef TDES_CBC_ECB_EN
  assign in_cbc = cbc_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cbc_q <= 1'b0;
    end else if (accept) begin
      cbc_q <= cbc_i;
    end
  end
`else
  assign in_cbc = 1'b1;
  assign cbc_q  = 1'b1;
`endif

  // Chain value the accepted block is combined with: a new chain starts from
  // the IV in the same cycle it is loaded, otherwise the running value.
  assign chain_new = (in_cbc && start_i) ? iv_i : chain_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    core_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = SEND;
      end
      SEND: begin
        // Start strobe only while the core is ready, so it fires exactly once.
        core_valid_o = core_ready_i;
        if (core_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (core_valid_i) state_d = OUT;
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mode_q      <= 1'b0;
      key1_q      <= '0;
      key2_q      <= '0;
      key3_q      <= '0;
      in_q        <= '0;
      chain_q     <= '0;
      core_data_q <= '0;
      data_q      <= '0;
    end else begin
      if (accept) begin
        mode_q      <= mode_i;
        key1_q      <= key1_i;
        key2_q      <= key2_i;
        key3_q      <= key3_i;
        in_q        <= data_i;
        chain_q     <= chain_new;
        // Encryption whitens the plaintext before the core; decryption sends
        // the ciphertext as-is and unchains on the way out instead.
        core_data_q <= (in_cbc && !mode_i) ? (data_i ^ chain_new) : data_i;
      end
      if ((state_q == WAIT) && core_valid_i) begin
        data_q <= (cbc_q && mode_q) ? (core_data_i ^ chain_q) : core_data_i;
        // The next chain value is always the ciphertext of this block.
        if (cbc_q) chain_q <= mode_q ? in_q : core_data_i;
      end
    end
  end

  assign data_o      = data_q;
  assign core_mode_o = mode_q;
  assign core_key1_o = key1_q;
  assign core_key2_o = key2_q;
  assign core_key3_o = key3_q;
  assign core_data_o = core_data_q;

endmodule

// File: tb/tb_tdes_cbc.sv
// tb_tdes_cbc: self-checking bench for tdes_cbc.
//
// A stand-in TDES core answers the controller's start handshake after a
// random latency. Its cipher is a simple keyed bijection, except that the
// known single-key DES vector (key 133457799BBCDFF1, 0123456789ABCDEF <->
// 85E813540F0AB405) is answered exactly so the reference CBC vectors apply.
// Expected results come from a CBC reference model and are queued at issue
// time; a monitor pops and compares whenever the DUT hands a result over.

module tb_tdes_cbc;

  localparam logic [63:0] DES_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] DES_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] DES_CT  = 64'h85E813540F0AB405;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        mode_i, start_i, valid_i, ready_i;
  logic [63:0] key1_i, key2_i, key3_i, iv_i, data_i;
  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic        core_mode_o, core_valid_o;
  logic [63:0] core_key1_o, core_key2_o, core_key3_o, core_data_o;
  logic        core_ready_i, core_valid_i;
  logic [63:0] core_data_i;
`ifdef TDES_CBC_ECB_EN
  logic        cbc_i = 1'b1;
`endif

  int          n_checks    = 0;
  int          miscompares = 0;
  int          cv_cycles   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ref_chain   = '0;
  logic [63:0] last_out    = '0;
  logic [63:0] last_core_data = '0;
  logic        last_core_mode = 1'b0;
  bit          core_manual = 1'b0;
  bit          core_ready_force = 1'b0;
  int          ds_mode     = 0;

  tdes_cbc dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
`ifdef TDES_CBC_ECB_EN
    .cbc_i        (cbc_i),
`endif
    .mode_i       (mode_i),
    .start_i      (start_i),
    .key1_i       (key1_i),
    .key2_i       (key2_i),
    .key3_i       (key3_i),
    .iv_i         (iv_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .core_mode_o  (core_mode_o),
    .core_key1_o  (core_key1_o),
    .core_key2_o  (core_key2_o),
    .core_key3_o  (core_key3_o),
    .core_data_o  (core_data_o),
    .core_valid_o (core_valid_o),
    .core_ready_i (core_ready_i),
    .core_data_i  (core_data_i),
    .core_valid_i (core_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in cipher for the TDES core.
  function automatic logic [63:0] core_func(input logic dec, input logic [63:0] x,
                                            input logic [63:0] k1, input logic [63:0] k2,
                                            input logic [63:0] k3);
    logic [63:0] y;
    if (k1 == DES_KEY && k2 == DES_KEY && k3 == DES_KEY) begin
      if (!dec && x == DES_PT) return DES_CT;
      if (dec && x == DES_CT) return DES_PT;
    end
    if (!dec) begin
      y = x ^ k1;
      y = {y[50:0], y[63:51]};
      y = y + k2;
      return y ^ k3;
    end else begin
      y = x ^ k3;
      y = y - k2;
      y = {y[12:0], y[63:13]};
      return y ^ k1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    miscompares++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Offer one block; the expected result is queued at the accept point.
  task automatic applyStimulus(input logic mode, input logic start, input logic [63:0] k1,
                               input logic [63:0] k2, input logic [63:0] k3,
                               input logic [63:0] iv, input logic [63:0] data);
    bit ok = 1'b0;
    logic [63:0] res;
    @(posedge clk_i);
    #1;
    mode_i = mode; start_i = start; key1_i = k1; key2_i = k2; key3_i = k3;
    iv_i = iv; data_i = data; valid_i = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      failNow("input_accept");
      valid_i = 1'b0;
      return;
    end
    if (start) ref_chain = iv;
    if (!mode) begin
      res = core_func(1'b0, data ^ ref_chain, k1, k2, k3);
      ref_chain = res;
    end else begin
      res = core_func(1'b1, data, k1, k2, k3) ^ ref_chain;
      ref_chain = data;
    end
    exp_q.push_back(res);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    bit ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1 && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("drain");
  endtask

  // Scoreboard monitor: a result is consumed on the edge after valid&ready.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        miscompares++;
        $display("[TB] FAIL unexpected_output: got %h, expected no output", data_o);
      end else begin
        checkOutput("data_o", data_o, exp_q.pop_front());
      end
      last_out = data_o;
    end
    if (core_valid_o === 1'b1) cv_cycles++;
  end

  // Downstream sink: random, held low, or held high.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ds_mode)
        0:       ready_i = ($urandom_range(0, 2) != 0);
        1:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  end

  // Stand-in TDES core with random ready and result latency.
  initial begin
    logic [63:0] res;
    int lat;
    core_ready_i = 1'b0;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!core_manual) begin
        core_ready_i = core_ready_force ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        if (core_valid_o === 1'b1) begin
          last_core_data = core_data_o;
          last_core_mode = core_mode_o;
          res = core_func(core_mode_o, core_data_o, core_key1_o, core_key2_o, core_key3_o);
          lat = $urandom_range(1, 4);
          @(posedge clk_i);
          #1 core_ready_i = 1'b0;
          if (lat > 1) begin
            repeat (lat - 1) @(posedge clk_i);
            #1;
          end
          core_data_i  = res;
          core_valid_i = 1'b1;
          @(posedge clk_i);
          #1 core_valid_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cv0;
    bit ok;
    logic [63:0] held;
    reset_i = 1'b0;
    mode_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    key1_i = '0; key2_i = '0; key3_i = '0; iv_i = '0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_ready_o", {63'd0, ready_o}, 64'd1);
    checkOutput("reset_valid_o", {63'd0, valid_o}, 64'd0);
    checkOutput("reset_data_o", data_o, 64'd0);
    checkOutput("reset_core_valid_o", {63'd0, core_valid_o}, 64'd0);
    checkOutput("reset_core_data_o", core_data_o, 64'd0);
    reset_i = 1'b1;

    $display("[TB] known-answer CBC sequence");
    core_ready_force = 1'b1;
    cv0 = cv_cycles;
    applyStimulus(1'b0, 1'b1, DES_KEY, DES_KEY, DES_KEY, 64'd0, DES_PT);
    #1 checkOutput("accept_to_core_valid", {63'd0, core_valid_o}, 64'd1);
    waitDrain();
    checkOutput("enc_iv0_out", last_out, DES_CT);
    checkOutput("core_valid_pulses", 64'(cv_cycles - cv0), 64'd1);

    applyStimulus(1'b0, 1'b0, DES_KEY, DES_KEY, DES_KEY, 64'd0, 64'h84CB563386A179EA);
    waitDrain();
    checkOutput("enc_chained_out", last_out, DES_CT);

    applyStimulus(1'b0, 1'b1, DES_KEY, DES_KEY, DES_KEY, DES_PT, 64'd0);
    waitDrain();
    checkOutput("enc_iv_core_data", last_core_data, DES_PT);
    checkOutput("enc_iv_out", last_out, DES_CT);

    applyStimulus(1'b1, 1'b1, DES_KEY, DES_KEY, DES_KEY, 64'd0, DES_CT);
    waitDrain();
    checkOutput("dec_out", last_out, DES_PT);
    checkOutput("dec_core_mode", {63'd0, last_core_mode}, 64'd1);
    core_ready_force = 1'b0;

    $display("[TB] randomized blocks");
    cv0 = cv_cycles;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), (i == 0) || ($urandom_range(0, 3) == 0),
                    {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    {$urandom(), $urandom()}, {$urandom(), $urandom()});
    end
    waitDrain();
    checkOutput("random_core_valid_pulses", 64'(cv_cycles - cv0), 64'd40);

    $display("[TB] downstream backpressure");
    ds_mode = 1;
    applyStimulus(1'b0, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("bp_valid_o");
    held = data_o;
    @(posedge clk_i);
    #1 data_i = {$urandom(), $urandom()}; start_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      checkOutput("bp_data_stable", data_o, held);
      checkOutput("bp_ready_o_low", {63'd0, ready_o}, 64'd0);
      checkOutput("bp_valid_o_held", {63'd0, valid_o}, 64'd1);
    end
    @(posedge clk_i);
    #1 valid_i = 1'b0; ds_mode = 2;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (ready_i === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("bp_release");
    @(negedge clk_i);
    checkOutput("bp_ready_o_after", {63'd0, ready_o}, 64'd1);
    checkOutput("bp_valid_o_after", {63'd0, valid_o}, 64'd0);
    ds_mode = 0;
    waitDrain();

    $display("[TB] reset while waiting on the core");
    core_manual = 1'b1;
    core_ready_i = 1'b1;
    applyStimulus(1'b0, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1;
    checkOutput("rst_valid_o", {63'd0, valid_o}, 64'd0);
    checkOutput("rst_ready_o", {63'd0, ready_o}, 64'd1);
    checkOutput("rst_data_o", data_o, 64'd0);
    exp_q.delete();
    ref_chain = '0;
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    core_data_i = {$urandom(), $urandom()};
    core_valid_i = 1'b1;
    @(posedge clk_i);
    #1 core_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("late_core_valid_no_out", {63'd0, valid_o}, 64'd0);
      checkOutput("late_core_valid_ready", {63'd0, ready_o}, 64'd1);
    end
    core_manual = 1'b0;

    applyStimulus(1'b1, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, miscompares);
    $finish;
  end

endmodule

// File: doc/tdes_cbc.md
Name: tdes_cbc

Overview:
- CBC chaining controller that acts as the initiator of the tdes core's valid/ready handshake.
- Accepts plaintext or ciphertext blocks from upstream and XORs them with the running chain value.
- Drives key, mode and data to an external tdes instance, collects its result, and presents output under downstream backpressure.
- Sits between a bus/stream front-end and the tdes core; both share clk_i and reset_i.

Parameters:
- none (block size fixed at 64, TDES keying option 1: three independent keys)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  reset, asynchronous, active-low
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- start_i  in  1  first block of a new chain; on accept, load iv_i as chain value
- key1_i, key2_i, key3_i  in  64 each  TDES keys; sampled on accept
- iv_i  in  64  initialisation vector; sampled on accept when start_i=1
- data_i  in  64  input block
- valid_i  in  1  input block valid
- ready_o  out  1  block can accept input
- data_o  out  64  result block
- valid_o  out  1  result valid; held until ready_i
- ready_i  in  1  downstream accepts result
- core_mode_o  out  1  mode to tdes core
- core_key1_o, core_key2_o, core_key3_o  out  64 each  keys to tdes core
- core_data_o  out  64  block to tdes core
- core_valid_o  out  1  start pulse to tdes core
- core_ready_i  in  1  tdes core ready
- core_data_i  in  64  tdes core result
- core_valid_i  in  1  tdes core result valid (1-cycle pulse)

Behaviour:
- Reset values: ready_o=1, valid_o=0, data_o=0, core_valid_o=0. Chain, input, mode and key registers = 0. State = IDLE.
- Accept = valid_i & ready_o.
- FSM IDLE -> SEND -> WAIT -> OUT -> IDLE.
- IDLE:
  - ready_o=1.
  - On accept: latch mode, keys and data_i. If start_i=1, chain <= iv_i; otherwise chain is retained.
  - core_data_o register <= data_i ^ chain(new) when encrypting; <= data_i when decrypting.
  - Next state SEND; ready_o=0 from the next cycle.
- SEND:
  - core_valid_o = core_ready_i (combinational, this state only).
  - When core_ready_i=1, go to WAIT. Exactly one core_valid_o cycle per block.
- WAIT:
  - On core_valid_i, data_o <= core_data_i (encrypt) or core_data_i ^ chain (decrypt).
  - Same edge: chain <= core_data_i (encrypt) or latched input ciphertext (decrypt).
  - Go to OUT.
- OUT:
  - valid_o=1, data_o stable.
  - On ready_i=1, go to IDLE; valid_o=0 and ready_o=1 next cycle.
- Latency: accept to core_valid_o is 1 cycle, given core_ready_i=1. core_valid_i to valid_o is 1 cycle.
- core_mode_o, core_key*_o, core_data_o are driven from the latched registers and are stable from SEND until the next accept.
- core_valid_i outside WAIT is ignored; no state change.
- valid_i while ready_o=0 is ignored; upstream must hold it.
- start_i is only meaningful when an accept occurs.
- A mode change without start_i continues with the existing chain value; no error is flagged.
- Asynchronous reset mid-operation returns all outputs and the chain to reset values. The next accept must use start_i=1 for defined results.

Optional Feature:
- Macro: TDES_CBC_ECB_EN.
- Defined: adds input port cbc_i (1 bit), sampled on accept.
  - cbc_i=0 selects ECB: no XOR on input or output, chain register not updated, iv_i/start_i ignored.
  - cbc_i=1 behaves as normal CBC.
- Undefined: port absent; block is always CBC.

Test Plan:
- Encrypt, start_i=1, iv=0, key1=key2=key3=0x133457799BBCDFF1, data=0x0123456789ABCDEF -> data_o=0x85E813540F0AB405; core_valid_o pulses exactly once.
- Chained second encrypt, start_i=0, same keys, data=0x84CB563386A179EA -> data_o=0x85E813540F0AB405, confirming the chain value was used.
- Encrypt, start_i=1, iv=0x0123456789ABCDEF, data=0 -> core_data_o=0x0123456789ABCDEF, data_o=0x85E813540F0AB405.
- Decrypt, start_i=1, iv=0, data=0x85E813540F0AB405 -> data_o=0x0123456789ABCDEF, core_mode_o=1.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> data_o stable, ready_o=0, a new valid_i is not accepted. Raise ready_i -> ready_o=1 the following cycle.
- Assert reset_i=0 while in WAIT -> valid_o=0, ready_o=1, data_o=0 immediately. A late core_valid_i after reset release produces no output.
